// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if.sv
// Power-switch sequencer request/status bundle.
//   master : domain controller side (drives PWR_REQ, and SW_FB when the
//            GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN feedback option is built in)
//   slave  : sequencer side (drives SW_EN, ISO_N, PWR_ACK, BUSY)
interface gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if #(
  parameter int unsigned N_BANKS = 8
);
  logic               PWR_REQ;
  logic [N_BANKS-1:0] SW_EN;
  logic               ISO_N;
  logic               PWR_ACK;
  logic               BUSY;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
  logic               SW_FB;

  modport master (output PWR_REQ, output SW_FB,
                  input  SW_EN, input ISO_N, input PWR_ACK, input BUSY);
  modport slave  (input  PWR_REQ, input SW_FB,
                  output SW_EN, output ISO_N, output PWR_ACK, output BUSY);
`else
  modport master (output PWR_REQ,
                  input  SW_EN, input ISO_N, input PWR_ACK, input BUSY);
  modport slave  (input  PWR_REQ,
                  output SW_EN, output ISO_N, output PWR_ACK, output BUSY);
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// Power-switch sequencer: ramps header-switch segments on one at a time
// (thermometer from bit 0) and releases isolation once all are on; ramps them
// off in reverse order with isolation asserted first.
// Ports:
//   VDD, VSS : power pins, only with USE_POWER_PINS
//   CLK      : clock, rising edge
//   RN       : asynchronous active-low reset
//   bus      : slave side of the request/status bundle
//              (PWR_REQ in; SW_EN, ISO_N, PWR_ACK, BUSY out; SW_FB in when
//               GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN is defined)
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN gates ON entry
// on a synchronized rail-good feedback.
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq #(
  parameter int unsigned N_BANKS     = 8,
  parameter int unsigned STEP_CYCLES = 4
) (
`ifdef USE_POWER_PINS
  inout wire  VDD,
  inout wire  VSS,
`endif
  input logic CLK,
  input logic RN,
  gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if.slave bus
);

  localparam int unsigned LVL_W  = $clog2(N_BANKS + 1);
  localparam int unsigned STEP_W = $clog2(STEP_CYCLES + 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(N_BANKS);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_ON      = 2'd2,
    ST_RAMP_DN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [N_BANKS-1:0]  sw_en_q, sw_en_d;
  logic                iso_n_q, iso_n_d;
  logic                pwr_ack_q, pwr_ack_d;
  logic                busy_q, busy_d;
  logic                step_done_c;
  logic                fb_ok_c;

`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
  // Two-flop synchronizer for the asynchronous rail-good feedback.
  logic fb_meta_q, fb_sync_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      fb_meta_q <= 1'b0;
      fb_sync_q <= 1'b0;
    end else begin
      fb_meta_q <= bus.SW_FB;
      fb_sync_q <= fb_meta_q;
    end
  end

  assign fb_ok_c = fb_sync_q;
`else
  assign fb_ok_c = 1'b1;
`endif

  assign step_done_c = (step_q == STEP_LAST);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    step_d  = step_q;

    unique case (state_q)
      ST_OFF: begin
        if (bus.PWR_REQ) begin
          state_d = ST_RAMP_UP;
          lvl_d   = LVL_W'(1);
          step_d  = '0;
        end
      end
      ST_RAMP_UP: begin
        // Abort wins over the step action.
        if (!bus.PWR_REQ) begin
          state_d = ST_RAMP_DN;
          step_d  = '0;
        end else if (!step_done_c) begin
          step_d = step_q + STEP_W'(1);
        end else if (lvl_q < LVL_MAX) begin
          lvl_d  = lvl_q + LVL_W'(1);
          step_d = '0;
        end else if (fb_ok_c) begin
          state_d = ST_ON;
          step_d  = '0;
        end
        // Otherwise STEP parks on its last value so ON follows the first
        // edge that sees the feedback.
      end
      ST_ON: begin
        if (!bus.PWR_REQ) begin
          state_d = ST_RAMP_DN;
          step_d  = '0;
        end
      end
      ST_RAMP_DN: begin
        if (bus.PWR_REQ) begin
          state_d = ST_RAMP_UP;
          step_d  = '0;
        end else if (!step_done_c) begin
          step_d = step_q + STEP_W'(1);
        end else begin
          step_d = '0;
          if (lvl_q <= LVL_W'(1)) begin
            lvl_d   = '0;
            state_d = ST_OFF;
          end else begin
            lvl_d = lvl_q - LVL_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_OFF;
        lvl_d   = '0;
        step_d  = '0;
      end
    endcase

    for (int unsigned i = 0; i < N_BANKS; i++) begin
      sw_en_d[i] = (lvl_d > LVL_W'(i));
    end
    iso_n_d   = (state_d == ST_ON);
    pwr_ack_d = (state_d == ST_ON);
    busy_d    = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DN);
  end

  // State and output registers; reset drops every segment at once.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_OFF;
      lvl_q     <= '0;
      step_q    <= '0;
      sw_en_q   <= '0;
      iso_n_q   <= 1'b0;
      pwr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      step_q    <= step_d;
      sw_en_q   <= sw_en_d;
      iso_n_q   <= iso_n_d;
      pwr_ack_q <= pwr_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.SW_EN   = sw_en_q;
  assign bus.ISO_N   = iso_n_q;
  assign bus.PWR_ACK = pwr_ack_q;
  assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// Bench for the power-switch sequencer: directed timelines from the power-up,
// power-down, abort, reset and toggle scenarios, then random PWR_REQ traffic
// against a closed-form reference model (level = base +/- elapsed/STEP).
module tb_gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq;

  localparam int N = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if #(.N_BANKS(N)) bus ();

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq #(.N_BANKS(N), .STEP_CYCLES(S)) dut (
`ifdef USE_POWER_PINS
    .VDD (vdd),
    .VSS (vss),
`endif
    .CLK (clk),
    .RN  (rn),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] therm(input int l);
    if (l <= 0) return 64'd0;
    return (64'd1 << l) - 64'd1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One active edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: since the last direction change the level moves one
  // segment per STEP cycles from a base level.
  localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3;
  int   m_mode = M_OFF;
  int   m_base = 0;
  int   m_t    = 0;
  logic m_fb1  = 1'b0;
  logic m_fb2  = 1'b0;

  function automatic int m_level();
    case (m_mode)
      M_UP:    return imin(N, m_base + m_t / S);
      M_ON:    return N;
      M_DN:    return imax(0, m_base - m_t / S);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rn) begin
    if (!rn) begin
      m_mode = M_OFF; m_base = 0; m_t = 0; m_fb1 = 1'b0; m_fb2 = 1'b0;
    end else begin : model_step
      int   lvl_now;
      logic fb_ok;
      lvl_now = m_level();
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
      fb_ok = m_fb2;
`else
      fb_ok = 1'b1;
`endif
      case (m_mode)
        M_OFF: if (bus.PWR_REQ) begin m_mode = M_UP; m_base = 1; m_t = 0; end
        M_UP: begin
          if (!bus.PWR_REQ) begin m_mode = M_DN; m_base = lvl_now; m_t = 0; end
          else begin
            m_t++;
            if (m_t >= (N - m_base + 1) * S && fb_ok) begin m_mode = M_ON; m_t = 0; end
          end
        end
        M_ON: if (!bus.PWR_REQ) begin m_mode = M_DN; m_base = N; m_t = 0; end
        default: begin
          if (bus.PWR_REQ) begin m_mode = M_UP; m_base = lvl_now; m_t = 0; end
          else begin
            m_t++;
            if (m_base - m_t / S <= 0) begin m_mode = M_OFF; m_base = 0; m_t = 0; end
          end
        end
      endcase
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
      m_fb2 = m_fb1;
      m_fb1 = bus.SW_FB;
`endif
    end
  end

  initial begin
    int hold;
    bus.PWR_REQ = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
    bus.SW_FB = 1'b1;
`endif
    rn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sw",   64'(bus.SW_EN),   64'd0);
    check("rst_iso",  64'(bus.ISO_N),   64'd0);
    check("rst_ack",  64'(bus.PWR_ACK), 64'd0);
    check("rst_busy", 64'(bus.BUSY),    64'd0);
    rn = 1'b1;
    repeat (3) tick();
    check("idle_sw", 64'(bus.SW_EN), 64'd0);

    // Power-up timeline.
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= N * S; e++) begin
      tick();
      check("up_sw",   64'(bus.SW_EN),   therm(imin(e / S + 1, N)));
      check("up_ack",  64'(bus.PWR_ACK), 64'(e >= N * S));
      check("up_iso",  64'(bus.ISO_N),   64'(e >= N * S));
      check("up_busy", 64'(bus.BUSY),    64'(e < N * S));
    end
    tick();
    check("on_ack", 64'(bus.PWR_ACK), 64'd1);

    // Power-down timeline.
    bus.PWR_REQ = 1'b0;
    for (int e = 0; e <= N * S; e++) begin
      tick();
      check("dn_sw",   64'(bus.SW_EN),   therm(N - e / S));
      check("dn_ack",  64'(bus.PWR_ACK), 64'd0);
      check("dn_iso",  64'(bus.ISO_N),   64'd0);
      check("dn_busy", 64'(bus.BUSY),    64'(e < N * S));
    end

    // Abort mid-ramp at edge 10 (SW_EN=0x07).
    tick();
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      if (e == 10) bus.PWR_REQ = 1'b0;
      tick();
      if (e < 10) check("ab_sw", 64'(bus.SW_EN), therm(e / S + 1));
      else        check("ab_sw", 64'(bus.SW_EN), therm(imax(0, 3 - (e - 10) / S)));
      check("ab_iso", 64'(bus.ISO_N), 64'd0);
    end
    check("ab_busy", 64'(bus.BUSY), 64'd0);

    // Asynchronous reset at SW_EN=0x1F.
    tick();
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= 16; e++) tick();
    check("mr_pre_sw", 64'(bus.SW_EN), 64'h1F);
    rn = 1'b0;
    #1;
    check("mr_sw",   64'(bus.SW_EN),   64'd0);
    check("mr_iso",  64'(bus.ISO_N),   64'd0);
    check("mr_ack",  64'(bus.PWR_ACK), 64'd0);
    check("mr_busy", 64'(bus.BUSY),    64'd0);
    @(negedge clk);
    rn = 1'b1;
    for (int e = 0; e <= S; e++) begin
      tick();
      check("mr_restart_sw", 64'(bus.SW_EN), therm(e / S + 1));
    end
    bus.PWR_REQ = 1'b0;
    repeat (N * S + 2) tick();
    check("mr_drain_sw", 64'(bus.SW_EN), 64'd0);

    // PWR_REQ toggling every cycle.
    for (int c = 0; c < 50; c++) begin
      bus.PWR_REQ = (c % 2 == 0);
      tick();
      check("tg_sw",  64'(bus.SW_EN),   64'h01);
      check("tg_ack", 64'(bus.PWR_ACK), 64'd0);
    end
    bus.PWR_REQ = 1'b0;
    repeat (S + 1) tick();
    check("tg_end_sw",   64'(bus.SW_EN), 64'd0);
    check("tg_end_busy", 64'(bus.BUSY),  64'd0);

`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
    // Rail feedback held low, raised at edge 40.
    bus.SW_FB = 1'b0;
    repeat (3) tick();
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= 45; e++) begin
      if (e == 40) bus.SW_FB = 1'b1;
      tick();
      check("fb_sw",  64'(bus.SW_EN),   therm(imin(e / S + 1, N)));
      check("fb_ack", 64'(bus.PWR_ACK), 64'(e >= 42));
    end
    bus.PWR_REQ = 1'b0;
    repeat (N * S + 2) tick();
    check("fb_drain_sw", 64'(bus.SW_EN), 64'd0);
`endif

    // Random traffic against the reference model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        bus.PWR_REQ = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                           : int'($urandom_range(1, 6));
      end
      hold--;
`ifdef GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN
      bus.SW_FB = ($urandom_range(0, 9) != 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        rn = 1'b0;
        #1;
        rn = 1'b1;
      end
      tick();
      check("rnd_sw",   64'(bus.SW_EN),   therm(m_level()));
      check("rnd_iso",  64'(bus.ISO_N),   64'(m_mode == M_ON));
      check("rnd_ack",  64'(bus.PWR_ACK), 64'(m_mode == M_ON));
      check("rnd_busy", 64'(bus.BUSY),    64'(m_mode == M_UP || m_mode == M_DN));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.md
# gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq

Power-switch sequencer for switchable power domains built from the 7-track 5V cell rows. It turns on a bank of header-switch segments one at a time, so the rail behind them fills without a large inrush current, and releases isolation only after the rail is up. It also turns the segments off in reverse order, asserting isolation first. It sits directly upstream of the switch/fill/decap rows it drives and consumes a single power request from the domain controller.

## Interface
Parameters:
- N_BANKS, 8: number of header-switch segments; must be ≥1.
- STEP_CYCLES, 4: CLK cycles between consecutive segment changes; must be ≥1.

Ports:
- CLK  input  1  clock; everything is sampled on the rising edge.
- RN  input  1  asynchronous active-low reset.
- VDD, VSS  inout  1  power pins; present only when USE_POWER_PINS is defined.
- PWR_REQ  input  1  level request: 1 means domain on, 0 means domain off.
- SW_EN  output  N_BANKS  switch-segment enables, always thermometer-coded from bit 0.
- ISO_N  output  1  isolation control, active-low (0 means outputs are clamped).
- PWR_ACK  output  1  high while the domain is fully on.
- BUSY  output  1  high while ramping up or down.
- SW_FB  input  1  rail-good feedback; present only under the feedback macro.

## Operation
- States: OFF, RAMP_UP, ON, RAMP_DN.
- Internal registers:
  - Level counter LVL, range 0..N_BANKS; SW_EN equals the low LVL bits set.
  - Step counter STEP, range 0..STEP_CYCLES-1, width $clog2(STEP_CYCLES+1).
- OFF:
  - Outputs: SW_EN=0, ISO_N=0, PWR_ACK=0, BUSY=0.
  - If PWR_REQ=1: go to RAMP_UP, set LVL=1, clear STEP.
- RAMP_UP:
  - BUSY=1.
  - When STEP reaches STEP_CYCLES-1: if LVL<N_BANKS, increment LVL; otherwise, if LVL==N_BANKS, go to ON. In both cases clear STEP.
  - If PWR_REQ=0: go to RAMP_DN, hold LVL, clear STEP. This abort has priority over the step action.
- ON:
  - ISO_N=1, PWR_ACK=1, BUSY=0, SW_EN all ones.
  - If PWR_REQ=0: go to RAMP_DN with ISO_N=0 and PWR_ACK=0 on the same edge; clear STEP.
- RAMP_DN:
  - BUSY=1, ISO_N=0.
  - When STEP reaches STEP_CYCLES-1: decrement LVL and clear STEP. If LVL reaches 0, go to OFF on that edge.
  - If PWR_REQ=1: go to RAMP_UP, hold LVL, clear STEP. The next segment is added one full step later.
- LVL never wraps: it saturates at 0 and at N_BANKS.
- Isolation is always asserted at least STEP_CYCLES cycles before any segment drops.
- All outputs are registered; no output depends combinationally on an input.

## Timing
- Reset: asynchronous and immediate. SW_EN=0, ISO_N=0, PWR_ACK=0, BUSY=0, state=OFF, counters=0.
- A reset in mid-ramp drops all segments at once; this is the accepted emergency behaviour.
- Power-up, with edge 0 being the first edge that samples PWR_REQ=1 in OFF:
  - SW_EN[i] rises at edge i·STEP_CYCLES.
  - PWR_ACK and ISO_N rise at edge N_BANKS·STEP_CYCLES.
- Power-down, with edge 0 being the first edge that samples PWR_REQ=0 in ON:
  - ISO_N and PWR_ACK fall at edge 0.
  - SW_EN[N_BANKS-1-j] falls at edge (j+1)·STEP_CYCLES.
  - OFF and BUSY=0 occur at edge N_BANKS·STEP_CYCLES.
- Special case N_BANKS=1, STEP_CYCLES=1: ACK one edge after SW_EN[0].
- PWR_REQ toggling every cycle: no state change other than direction flips; LVL stays constant because STEP never completes.

## Configuration
- Macro: GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ_FB_EN.
- Defined:
  - SW_FB port exists and passes through a 2-flop synchronizer inside the block.
  - The RAMP_UP→ON transition additionally requires synchronized SW_FB=1. RAMP_UP holds at LVL=N_BANKS until it is seen, with ON entered on the first edge where both conditions hold.
  - SW_FB is ignored in all other states.
- Undefined: no SW_FB port; the ON entry time is purely the fixed timing above.

## Test plan
- Reset, then PWR_REQ=1 at edge 0, with N_BANKS=8, STEP_CYCLES=4: SW_EN goes 0x01@0, 0x03@4, …, 0xFF@28; PWR_ACK=ISO_N=1@32; BUSY low@32.
- From ON, PWR_REQ=0 at edge 0: ISO_N=0 and PWR_ACK=0@0; SW_EN goes 0x7F@4, …, 0x00@32; BUSY=0@32.
- Abort: PWR_REQ=1@0, then 0@10 (SW_EN=0x07). Expect RAMP_DN with SW_EN 0x03@14, 0x01@18, 0x00@22; ISO_N stays 0 throughout.
- RN pulsed low at SW_EN=0x1F mid-ramp: all outputs 0 asynchronously, before the next CLK edge; after release with PWR_REQ=1, the ramp restarts from 0x01.
- Saturation and toggling: PWR_REQ toggled every cycle for 50 cycles from OFF. SW_EN stays 0x01, never wraps or underflows, and PWR_ACK never rises.
- With FB_EN, SW_FB held low: SW_EN=0xFF and PWR_ACK=0 indefinitely. Raising SW_FB at edge 40 gives PWR_ACK=1@42.
